sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Arbitrates the single external 8-bit asynchronous SRAM (20-bit address) between two requesters: the Atari cartridge bus (read-only, time-critical, strict priority) and the Nios II host (Avalon-MM slave, read/write, used for loading cartridge images). Sits between the Atari bus decoder and the SRAM pins. It sequences CE/OE/WE and the data-bus tristate enable, and returns latched read data to each side.

## Interface
Parameters:
- ADDR_W, 20, SRAM address width
- RD_CYCLES, 2, clocks OE_n is held low per read (≥1)
- WR_CYCLES, 2, clocks WE_n is held low per write (≥1)

Ports:
- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset_n  in  1  asynchronous, active-low reset
- atari_bus_driven  in  1  Atari cycle in progress; host access must not start while high
- atari_sram_enable  in  1  Atari requests SRAM reads at atari_sram_addr
- atari_sram_addr  in  ADDR_W  Atari read address (synchronous to clk_clk)
- atari_sram_data  out  8  last Atari read data, registered
- avs_address  in  ADDR_W  host address
- avs_read  in  1  host read request
- avs_write  in  1  host write request
- avs_writedata  in  8  host write data
- avs_readdata  out  8  host read data, registered
- avs_waitrequest  out  1  Avalon waitrequest
- sram_addr  out  ADDR_W  SRAM address pins
- sram_dq_in  in  8  SRAM data pins, input side
- sram_dq_out  out  8  SRAM data pins, output side
- sram_dq_oe  out  1  1 = FPGA drives sram_dq
- sram_ce  out  1  chip enable, active high
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low

## Operation
- States: IDLE, A_RD, H_RD, H_WR_SETUP, H_WR_PULSE, H_WR_HOLD, H_DONE.
- Atari pending = atari_sram_enable && (no valid Atari data || atari_sram_addr != last_atari_addr). Registered last_atari_addr/valid flag; valid cleared when enable is low.
- IDLE: Atari pending -> A_RD (priority, including simultaneous with host). Else (avs_read||avs_write) && !atari_bus_driven -> H_RD or H_WR_SETUP (read wins if both asserted; that is a master error, not checked).
- A_RD: sram_addr=atari_sram_addr latched at entry, ce=1, oe_n=0 for RD_CYCLES; on last cycle capture sram_dq_in into atari_sram_data, update last_atari_addr, valid=1 -> IDLE.
- H_RD: same timing with avs_address; capture into avs_readdata -> H_DONE.
- H_WR_SETUP (1 clk): addr, dq_out=avs_writedata, dq_oe=1, ce=1, we_n=1. H_WR_PULSE: we_n=0 for WR_CYCLES. H_WR_HOLD (1 clk): we_n=1, dq_oe=1, addr stable -> H_DONE.
- H_DONE (1 clk): avs_waitrequest=0, all SRAM controls idle -> IDLE.
- avs_waitrequest=1 in every state except H_DONE; host accesses are never preempted once started.
- oe_n and we_n never both low; dq_oe=1 only in H_WR_* states; oe_n=1 in any cycle where dq_oe=1.
- IDLE outputs: ce=0, oe_n=1, we_n=1, dq_oe=0, sram_addr holds last value.

## Timing
- Reset (async, any state): sram_ce=0, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, atari_sram_data=0x00, avs_readdata=0x00, avs_waitrequest=1, valid=0, state IDLE. In-flight host access dropped; master must reissue.
- Atari read latency: pending sampled in IDLE, then RD_CYCLES in A_RD; atari_sram_data updates 1+RD_CYCLES clocks after request seen (3 at defaults).
- Worst-case Atari latency: one complete host write (1+WR_CYCLES+1+1 = 5 clk) plus 1+RD_CYCLES = 8 clk at defaults; the Atari side design budget relies on this bound.
- Host read: 1+RD_CYCLES+1 clocks from IDLE acceptance to waitrequest low (4 at defaults); host write: 1+1+WR_CYCLES+1+1 (6 at defaults).
- Atari address change during A_RD: current read completes with the old address; new read starts on the next IDLE cycle.
- atari_sram_enable falling during A_RD: read completes, then valid cleared.

## Test plan
- Reset mid H_WR_PULSE: assert reset_reset_n=0 -> same cycle we_n=1, dq_oe=0, ce=0, waitrequest=1; after release, no write occurs at that address (readback shows old value).
- Host write 0xA5 to 0x12345, then read -> we_n low exactly 2 clk, dq driven from setup through hold; read returns 0xA5, waitrequest low 1 clk at cycle 6 (write) and cycle 4 (read).
- Atari enable with addr 0x00010, SRAM model holds 0x3C -> atari_sram_data=0x3C 3 clk later; address unchanged -> no further A_RD cycles.
- Simultaneous Atari request and host read in IDLE -> A_RD first, then H_RD; host waitrequest stays high until A_RD completes.
- Host write accepted, Atari request arrives in H_WR_PULSE -> write finishes uninterrupted, A_RD starts immediately after H_DONE; Atari data valid ≤8 clk after request.
- atari_bus_driven=1 with host read pending and no Atari request -> no SRAM cycle starts; read begins the clock after atari_bus_driven falls.

Source files
------------

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 8-bit SRAM between the Atari cartridge bus (strict-priority reads)
// and the Nios II host (Avalon-MM reads/writes). All SRAM pins and returned data are registered.
module sram_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              atari_bus_driven,
  input  logic              atari_sram_enable,
  input  logic [ADDR_W-1:0] atari_sram_addr,
  output logic [7:0]        atari_sram_data,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [7:0]        avs_writedata,
  output logic [7:0]        avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [7:0]        sram_dq_in,
  output logic [7:0]        sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_ce,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [2:0] {
    IDLE, A_RD, H_RD, H_WR_SETUP, H_WR_PULSE, H_WR_HOLD, H_DONE
  } state_e;

  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                ce_q, ce_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                wait_q, wait_d;
  logic [7:0]          atari_data_q, atari_data_d;
  logic [7:0]          host_data_q, host_data_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic                valid_q, valid_d;
  logic                atari_pending;

  // A held address that was already fetched is not re-read; a new address or re-enable is.
  assign atari_pending = atari_sram_enable &&
                         (!valid_q || (atari_sram_addr != last_addr_q));

  always_comb begin
    // NOTE: every _d signal gets a default here so no branch can leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = '0;
    addr_d       = addr_q;
    dq_out_d     = dq_out_q;
    dq_oe_d      = 1'b0;
    ce_d         = 1'b0;
    oe_n_d       = 1'b1;
    we_n_d       = 1'b1;
    wait_d       = 1'b1;
    atari_data_d = atari_data_q;
    host_data_d  = host_data_q;
    last_addr_d  = last_addr_q;
    valid_d      = valid_q && atari_sram_enable;

    unique case (state_q)
      IDLE: begin
        if (atari_pending) begin
          state_d = A_RD;
          addr_d  = atari_sram_addr;
          ce_d    = 1'b1;
          oe_n_d  = 1'b0;
        end else if ((avs_read || avs_write) && !atari_bus_driven) begin
          addr_d = avs_address;
          ce_d   = 1'b1;
          if (avs_read) begin
            state_d = H_RD;
            oe_n_d  = 1'b0;
          end else begin
            state_d  = H_WR_SETUP;
            dq_out_d = avs_writedata;
            dq_oe_d  = 1'b1;
          end
        end
      end

      A_RD: begin
        if (cnt_q == RD_LAST) begin
          state_d      = IDLE;
          atari_data_d = sram_dq_in;
          last_addr_d  = addr_q;
          valid_d      = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          ce_d   = 1'b1;
          oe_n_d = 1'b0;
        end
      end

      H_RD: begin
        if (cnt_q == RD_LAST) begin
          state_d     = H_DONE;
          host_data_d = sram_dq_in;
          wait_d      = 1'b0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          ce_d   = 1'b1;
          oe_n_d = 1'b0;
        end
      end

      H_WR_SETUP: begin
        state_d = H_WR_PULSE;
        ce_d    = 1'b1;
        dq_oe_d = 1'b1;
        we_n_d  = 1'b0;
      end

      H_WR_PULSE: begin
        ce_d    = 1'b1;
        dq_oe_d = 1'b1;
        if (cnt_q == WR_LAST) begin
          state_d = H_WR_HOLD;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          we_n_d = 1'b0;
        end
      end

      H_WR_HOLD: begin
        state_d = H_DONE;
        wait_d  = 1'b0;
      end

      H_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!reset_reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      dq_out_q     <= '0;
      dq_oe_q      <= 1'b0;
      ce_q         <= 1'b0;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      wait_q       <= 1'b1;
      atari_data_q <= '0;
      host_data_q  <= '0;
      last_addr_q  <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      dq_out_q     <= dq_out_d;
      dq_oe_q      <= dq_oe_d;
      ce_q         <= ce_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      wait_q       <= wait_d;
      atari_data_q <= atari_data_d;
      host_data_q  <= host_data_d;
      last_addr_q  <= last_addr_d;
      valid_q      <= valid_d;
    end
  end

  assign sram_addr       = addr_q;
  assign sram_dq_out     = dq_out_q;
  assign sram_dq_oe      = dq_oe_q;
  assign sram_ce         = ce_q;
  assign sram_oe_n       = oe_n_q;
  assign sram_we_n       = we_n_q;
  assign avs_waitrequest = wait_q;
  assign avs_readdata    = host_data_q;
  assign atari_sram_data = atari_data_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: pin-level SRAM model, directed host vector table, multi-cycle corner
// sequences and a randomized phase checked against a flat reference memory.
module tb_sram_arbiter;

  localparam int RD_CYC      = 2;
  localparam int WR_CYC      = 2;
  localparam int ATARI_CYC   = 1 + RD_CYC;
  localparam int HOST_RD_CYC = 1 + RD_CYC + 1;
  localparam int HOST_WR_CYC = 1 + 1 + WR_CYC + 1 + 1;
  localparam int WORST_ATARI = (1 + WR_CYC + 1 + 1) + (1 + RD_CYC);
  localparam logic [19:0] RND_BASE = 20'h40000;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        atari_bus_driven, atari_sram_enable;
  logic [19:0] atari_sram_addr, avs_address, sram_addr;
  logic [7:0]  atari_sram_data, avs_writedata, avs_readdata, sram_dq_in, sram_dq_out;
  logic        avs_read, avs_write, avs_waitrequest;
  logic        sram_dq_oe, sram_ce, sram_oe_n, sram_we_n;

  sram_arbiter #(.ADDR_W(20), .RD_CYCLES(RD_CYC), .WR_CYCLES(WR_CYC)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .atari_bus_driven(atari_bus_driven), .atari_sram_enable(atari_sram_enable),
    .atari_sram_addr(atari_sram_addr), .atari_sram_data(atari_sram_data),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest), .sram_addr(sram_addr),
    .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_ce(sram_ce), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #5 clk_clk = ~clk_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Physical SRAM contents (written only through the pins) and the expected contents.
  logic [7:0] sram_mem [logic [19:0]];
  logic [7:0] ref_mem  [logic [19:0]];

  function automatic logic [7:0] mem_rd(input logic [19:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // SRAM pin model sampled mid-cycle: a write commits when WE_n rises with CE still high.
  bit          we_seen = 0;
  logic [19:0] wr_a;
  logic [7:0]  wr_d;
  int          we_lo_cnt = 0, dq_cnt = 0, oe_cnt = 0, viol = 0;

  always @(negedge clk_clk) begin
    if (!sram_ce) we_seen = 0;
    else if (!sram_we_n && sram_dq_oe) begin
      we_seen = 1; wr_a = sram_addr; wr_d = sram_dq_out; we_lo_cnt++;
    end else if (we_seen && sram_we_n) begin
      sram_mem[wr_a] = wr_d; we_seen = 0;
    end
    if (sram_dq_oe) dq_cnt++;
    if (!sram_oe_n) oe_cnt++;
    if (!sram_oe_n && !sram_we_n) viol++;
    if (sram_dq_oe && !sram_oe_n) viol++;
    sram_dq_in = (sram_ce && !sram_oe_n) ? mem_rd(sram_addr) : 8'hEE;
  end

  // Host transaction; cyc counts clock cycles with the request cycle as 1.
  task automatic host_xact(input bit wr, input logic [19:0] a, input logic [7:0] wd,
                           output logic [7:0] rd, output int cyc);
    @(negedge clk_clk);
    we_lo_cnt = 0; dq_cnt = 0;
    avs_address = a; avs_writedata = wd; avs_read = !wr; avs_write = wr;
    cyc = 1;
    while (1) begin
      @(posedge clk_clk); #1;
      cyc++;
      if (!avs_waitrequest) break;
      if (cyc > 60) begin check("host_timeout", avs_waitrequest, 1'b0); break; end
    end
    rd = avs_readdata;
    @(posedge clk_clk); #1;
    avs_read = 0; avs_write = 0;
    if (wr) ref_mem[a] = wd;
  endtask

  // Atari read; edges = rising clock edges until atari_sram_data changes (bounded).
  task automatic atari_req(input logic [19:0] a, output int edges);
    logic [7:0] prev;
    @(negedge clk_clk);
    prev = atari_sram_data;
    atari_sram_addr = a; atari_sram_enable = 1;
    edges = 0;
    do begin @(posedge clk_clk); #1; edges++; end
    while (atari_sram_data == prev && edges < 12);
  endtask

  typedef struct {
    bit          wr;
    logic [19:0] addr;
    logic [7:0]  data;
    int          exp_cyc;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] rd, atari_model;
  int         cyc, e;

  initial begin
    vecs[0] = '{1'b1, 20'h12345, 8'hA5, HOST_WR_CYC};
    vecs[1] = '{1'b0, 20'h12345, 8'hA5, HOST_RD_CYC};
    vecs[2] = '{1'b1, 20'h00000, 8'h00, HOST_WR_CYC};
    vecs[3] = '{1'b1, 20'hFFFFF, 8'hFF, HOST_WR_CYC};
    vecs[4] = '{1'b0, 20'hFFFFF, 8'hFF, HOST_RD_CYC};
    vecs[5] = '{1'b0, 20'h00000, 8'h00, HOST_RD_CYC};
    vecs[6] = '{1'b1, 20'h00001, 8'h5A, HOST_WR_CYC};
    vecs[7] = '{1'b0, 20'h00001, 8'h5A, HOST_RD_CYC};

    foreach (vecs[i]) if (!vecs[i].wr) ; // table is fully defined above
    sram_mem[20'h00010] = 8'h3C; ref_mem[20'h00010] = 8'h3C;
    sram_mem[20'h00020] = 8'h77; ref_mem[20'h00020] = 8'h77;
    sram_mem[20'h00030] = 8'h99; ref_mem[20'h00030] = 8'h99;
    sram_mem[20'h00400] = 8'h11; ref_mem[20'h00400] = 8'h11;
    for (int i = 0; i < 16; i++) begin
      sram_mem[RND_BASE + 20'(i)] = 8'(i * 17 + 3);
      ref_mem[RND_BASE + 20'(i)]  = 8'(i * 17 + 3);
    end

    reset_reset_n = 0; atari_bus_driven = 0; atari_sram_enable = 0; atari_sram_addr = '0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
    repeat (3) @(negedge clk_clk);
    check("rst_ce", sram_ce, 1'b0);
    check("rst_oe_n", sram_oe_n, 1'b1);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_dq_oe", sram_dq_oe, 1'b0);
    check("rst_addr", sram_addr, 20'h0);
    check("rst_dq_out", sram_dq_out, 8'h00);
    check("rst_atari_data", atari_sram_data, 8'h00);
    check("rst_readdata", avs_readdata, 8'h00);
    check("rst_wait", avs_waitrequest, 1'b1);
    reset_reset_n = 1;

    // Host vector table.
    for (int i = 0; i < 8; i++) begin
      host_xact(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, cyc);
      check($sformatf("vec%0d_cyc", i), cyc, vecs[i].exp_cyc);
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_we_lo", i), we_lo_cnt, WR_CYC);
        check($sformatf("vec%0d_dq_oe", i), dq_cnt, WR_CYC + 2);
        check($sformatf("vec%0d_mem", i), mem_rd(vecs[i].addr), vecs[i].data);
      end else begin
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].data);
      end
    end

    // Atari read, then held address must not re-read.
    atari_req(20'h00010, e);
    check("atari_lat", e, ATARI_CYC);
    check("atari_data", atari_sram_data, 8'h3C);
    oe_cnt = 0;
    repeat (6) @(negedge clk_clk);
    check("atari_no_reread", oe_cnt, 0);
    atari_sram_enable = 0;

    // Simultaneous Atari and host read: Atari first.
    fork
      atari_req(20'h00020, e);
      host_xact(1'b0, 20'h12345, 8'h00, rd, cyc);
    join
    check("simul_atari_lat", e, ATARI_CYC);
    check("simul_atari_data", atari_sram_data, 8'h77);
    check("simul_host_cyc", cyc, ATARI_CYC + HOST_RD_CYC);
    check("simul_host_rdata", rd, 8'hA5);
    @(negedge clk_clk); atari_sram_enable = 0;

    // Atari request arriving during the write pulse waits for the whole write.
    fork
      host_xact(1'b1, 20'h00300, 8'h42, rd, cyc);
      begin repeat (2) @(negedge clk_clk); atari_req(20'h00030, e); end
    join
    check("wc_host_cyc", cyc, HOST_WR_CYC);
    check("wc_atari_lat", e, WORST_ATARI - 1);
    check("wc_atari_bound", e <= WORST_ATARI, 1'b1);
    check("wc_atari_data", atari_sram_data, 8'h99);
    @(negedge clk_clk); atari_sram_enable = 0;

    // atari_bus_driven blocks host start until it falls.
    atari_bus_driven = 1;
    fork
      host_xact(1'b0, 20'h00300, 8'h00, rd, cyc);
      begin
        @(negedge clk_clk); oe_cnt = 0;
        repeat (5) @(posedge clk_clk);
        @(negedge clk_clk);
        check("busdrv_no_cycle", oe_cnt, 0);
        atari_bus_driven = 0;
      end
    join
    check("busdrv_host_cyc", cyc, 5 + HOST_RD_CYC);
    check("busdrv_rdata", rd, 8'h42);

    // Reset in the middle of a write pulse aborts the write.
    @(negedge clk_clk);
    avs_address = 20'h00400; avs_writedata = 8'hEE; avs_write = 1;
    @(posedge clk_clk); @(posedge clk_clk);
    @(negedge clk_clk);
    check("midrst_pulse_active", sram_we_n, 1'b0);
    reset_reset_n = 0; #1;
    check("midrst_we_n", sram_we_n, 1'b1);
    check("midrst_dq_oe", sram_dq_oe, 1'b0);
    check("midrst_ce", sram_ce, 1'b0);
    check("midrst_wait", avs_waitrequest, 1'b1);
    check("midrst_atari_data", atari_sram_data, 8'h00);
    avs_write = 0;
    @(negedge clk_clk); reset_reset_n = 1;
    host_xact(1'b0, 20'h00400, 8'h00, rd, cyc);
    check("midrst_old_value", rd, 8'h11);
    atari_model = 8'h00;

    // Randomized traffic against the reference memory.
    for (int it = 0; it < 40; it++) begin
      int          op, d;
      bit          hw;
      logic [19:0] ha, aa;
      logic [7:0]  hd, exp_a, exp_h;
      op = $urandom_range(0, 3);
      ha = RND_BASE + 20'($urandom_range(0, 15));
      aa = ha ^ 20'h1;
      hd = 8'($urandom_range(0, 255));
      case (op)
        0: begin
          host_xact(1'b1, ha, hd, rd, cyc);
          check("rnd_wr_cyc", cyc, HOST_WR_CYC);
        end
        1: begin
          exp_h = ref_rd(ha);
          host_xact(1'b0, ha, 8'h00, rd, cyc);
          check("rnd_rd_cyc", cyc, HOST_RD_CYC);
          check("rnd_rd_data", rd, exp_h);
        end
        2: begin
          exp_a = ref_rd(aa);
          atari_req(aa, e);
          check("rnd_atari_data", atari_sram_data, exp_a);
          if (exp_a != atari_model) check("rnd_atari_lat", e, ATARI_CYC);
          atari_model = exp_a;
          @(negedge clk_clk); atari_sram_enable = 0;
        end
        default: begin
          hw = 1'($urandom_range(0, 1));
          d  = $urandom_range(0, 4);
          exp_h = ref_rd(ha);
          exp_a = ref_rd(aa);
          fork
            host_xact(hw, ha, hd, rd, cyc);
            begin repeat (d) @(negedge clk_clk); atari_req(aa, e); end
          join
          if (!hw) check("rnd_mix_rd_data", rd, exp_h);
          check("rnd_mix_atari_data", atari_sram_data, exp_a);
          if (exp_a != atari_model) check("rnd_mix_atari_bound", e <= WORST_ATARI, 1'b1);
          atari_model = exp_a;
          @(negedge clk_clk); atari_sram_enable = 0;
        end
      endcase
    end

    // Final readback of the random window through the host port.
    for (int i = 0; i < 16; i++) begin
      host_xact(1'b0, RND_BASE + 20'(i), 8'h00, rd, cyc);
      check($sformatf("final_mem_%0d", i), rd, ref_rd(RND_BASE + 20'(i)));
    end
    check("protocol_violations", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
